// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_lane_ext.sv
// Picks the addressed byte/half/word out of a 32-bit little-endian word and
// sign- or zero-extends it to 32 bits.
module dmem_lane_ext (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);
  import dmem_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = word[{lane, 3'b000} +: 8];
    h    = lane[1] ? word[31:16] : word[15:0];
    data = '0;
    case (size)
      SZ_BYTE: data = {{24{~is_unsigned & b[7]}}, b};
      SZ_HALF: data = {{16{~is_unsigned & h[15]}}, h};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with byte/half/word access and fixed read latency.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of force-aligning them.
module data_mem_ctrl #(
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int TEST_WIDTH   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [31:0]           WD,
  output logic                  rsp_valid,
  output logic [31:0]           RD,
  output logic                  rsp_err,
  output logic [TEST_WIDTH-1:0] test_value
);
  import dmem_pkg::*;

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [2:0]       cnt;
  logic [IW-1:0]    idx;
  logic [IDX_W-1:0] widx;
  logic [1:0]       lane;
  logic             in_range, misalign, err, accept, wr_en;
  logic [3:0]       be;
  logic [31:0]      wd_lane, rd_word, ext;
  logic [31:0]      rd_p0;
  logic             err_p0;

  assign idx      = A[ADDR_WIDTH-1:2];
  assign in_range = idx < IW'(DEPTH);
  assign widx     = idx[IDX_W-1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign lane     = A[1:0];
  assign misalign = ((req_size == SZ_HALF) && A[0]) ||
                    ((req_size == SZ_WORD) && (A[1:0] != 2'b00));
`else
  always_comb begin
    lane = A[1:0];
    if (req_size == SZ_HALF)      lane[0] = 1'b0;
    else if (req_size == SZ_WORD) lane    = 2'b00;
  end
  assign misalign = 1'b0;
`endif

  assign err       = (req_size == SZ_RSVD) | ~in_range | misalign;
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign wr_en     = accept & req_we & ~err;

  always_comb begin
    case (req_size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wd_lane = WD << {lane, 3'b000};
  assign rd_word = in_range ? mem[widx] : '0;

  dmem_lane_ext u_lane_ext (
    .word        (rd_word),
    .lane        (lane),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .data        (ext)
  );

  // Storage: cleared as a whole by reset, stores land at the acceptance edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wd_lane[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          if (READ_LATENCY == 1) begin
            state <= ST_RESP;
          end else begin
            state <= ST_BUSY;
            cnt   <= 3'(READ_LATENCY - 2);
          end
        end
        ST_BUSY: if (cnt == 3'd0) state <= ST_RESP;
                 else             cnt   <= cnt - 3'd1;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p0: load result snapshot taken at acceptance, exposed only during RESP.
  always_ff @(posedge CLK) begin
    if (accept) begin
      err_p0 <= err;
      rd_p0  <= (err | req_we) ? '0 : ext;
    end
  end

  assign rsp_valid  = (state == ST_RESP);
  assign rsp_err    = rsp_valid & err_p0;
  assign RD         = rsp_valid ? rd_p0 : '0;
  assign test_value = mem[0][TEST_WIDTH-1:0];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: byte-array memory model plus per-cycle output compare.
module tb_data_mem_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int LAT   = 3;
  localparam int TW    = 16;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] A = '0;
  logic [31:0]   WD = '0;
  logic          rsp_valid;
  logic [31:0]   RD;
  logic          rsp_err;
  logic [TW-1:0] test_value;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(
    .DEPTH        (DEPTH),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (LAT),
    .TEST_WIDTH   (TW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .A            (A),
    .WD           (WD),
    .rsp_valid    (rsp_valid),
    .RD           (RD),
    .rsp_err      (rsp_err),
    .test_value   (test_value)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          busy_left = 0;
  int          cap_lat = 0;
  int          nrdy = 0;
  logic [31:0] mmem [DEPTH];
  logic [31:0] exp_rd = '0;
  logic        exp_err = 1'b0;
  logic [31:0] cap_rd = '0;
  logic        cap_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: resolve the request byte by byte against the model memory.
  task automatic model_accept();
    int                 idx, lane, nb;
    bit                 err;
    logic [63:0]        val;
    idx  = int'(A >> 2);
    lane = int'(A[1:0]);
    nb   = (req_size == 2'b00) ? 1 : (req_size == 2'b01) ? 2 : 4;
    err  = (req_size == 2'b11) || (idx >= DEPTH);
    if (TRAP) err = err || ((lane % nb) != 0);
    else      lane = lane - (lane % nb);
    exp_err = err;
    exp_rd  = '0;
    if (!err) begin
      if (req_we) begin
        for (int k = 0; k < nb; k++) mmem[idx][8*(lane+k) +: 8] = WD[8*k +: 8];
      end else begin
        val = '0;
        for (int k = 0; k < nb; k++) val = val | (64'(mmem[idx][8*(lane+k) +: 8]) << (8*k));
        if (!req_unsigned && val[8*nb-1]) val = val | (~64'd0 << (8*nb));
        exp_rd = val[31:0];
      end
    end
  endtask

  task automatic compare();
    bit ev;
    ev = (busy_left == 1);
    chk("rsp_valid",  32'(rsp_valid),  32'(ev));
    chk("req_ready",  32'(req_ready),  32'(busy_left == 0));
    chk("RD",         RD,              ev ? exp_rd : 32'h0);
    chk("rsp_err",    32'(rsp_err),    32'(ev & exp_err));
    chk("test_value", 32'(test_value), 32'(mmem[0][TW-1:0]));
    if (rsp_valid === 1'b1) begin
      cap_rd  = RD;
      cap_err = rsp_err;
      cap_lat = cyc - acc_cyc;
    end
    if (req_ready === 1'b0) nrdy++;
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    if (!RST) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (req_valid) begin
      model_accept();
      busy_left = LAT;
      acc_cyc   = cyc - 1;
    end
    @(negedge CLK);
    compare();
  endtask

  // One transaction; while it is in flight the request pins carry junk that must be ignored.
  task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; A = addr; WD = wd;
    nrdy = 0; cap_rd = 32'hA5A5A5A5; cap_err = 1'b1; cap_lat = -1;
    tick();
    req_we = 1'b1; req_size = 2'($urandom); A = $urandom & 32'h3F; WD = $urandom;
    for (int i = 0; i < LAT && busy_left > 0; i++) tick();
    req_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_RD"},         RD,              32'd0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'd0);
    chk({tag, "_test_value"}, 32'(test_value), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    RST = 1'b0;
    #1;
    busy_left = 0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    reset_checks(tag);
    tick();
    tick();
    RST = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    #2;
    apply_reset("rst");

    // Word store then load of word 0
    req(1'b1, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF);
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("ld_word0",     cap_rd,              32'hDEADBEEF);
    chk("ld_word0_err", 32'(cap_err),        32'd0);
    chk("tv_beef",      32'(test_value),     32'h0000BEEF);
    chk("latency",      32'(cap_lat),        32'd3);
    chk("ready_low",    32'(nrdy),           32'd3);

    // Byte store into lane 1 of word 1, signed/unsigned reads
    req(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344);
    req(1'b1, 2'b00, 1'b0, 32'h5, 32'h00000080);
    req(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
    chk("ld_byte_s", cap_rd, 32'hFFFFFF80);
    req(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    chk("ld_byte_u", cap_rd, 32'h00000080);
    req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("word1_lanes", cap_rd, 32'h11228044);

    // Misaligned word load
    req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    chk("misal_word_rd",  cap_rd,       TRAP ? 32'h0 : 32'hDEADBEEF);
    chk("misal_word_err", 32'(cap_err), TRAP ? 32'd1 : 32'd0);

    // Out-of-range index and reserved size
    req(1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0);
    chk("oor_err", 32'(cap_err), 32'd1);
    chk("oor_rd",  cap_rd,       32'h0);
    req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("rsvd_err", 32'(cap_err), 32'd1);
    req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF);
    req(1'b1, 2'b10, 1'b0, DEPTH * 4, 32'h12345678);
    chk("oor_st_err", 32'(cap_err), 32'd1);
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("mem_unchanged", cap_rd, 32'hDEADBEEF);

    // Half accesses
    req(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000ABCD);
    req(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    chk("ld_half_s", cap_rd, 32'hFFFFABCD);
    req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    chk("ld_half_u", cap_rd, 32'h00001122);
    chk("tv_after_half", 32'(test_value), 32'h0000BEEF);
    req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
    chk("misal_half_rd", cap_rd, TRAP ? 32'h0 : 32'hFFFFABCD);

    // Reset while a load is in BUSY
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; A = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    apply_reset("rst_busy");
    req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("ld_after_rst",     cap_rd,       32'h0);
    chk("ld_after_rst_err", 32'(cap_err), 32'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
